// File: rtl/matrix_ctrl_pkg.sv
// matrix_ctrl_pkg
// Shared widths, limits and the sequencer state type for matrix_mult_ctrl
// and its result-hold sub-module.
package matrix_ctrl_pkg;

  localparam int DATA_W        = 8;
  localparam int ACC_W         = 16;

  localparam int FRAME_LEN_MAX = 255;
  localparam int MULT_LAT_MAX  = 7;

  // Sample counter must reach FRAME_LEN itself; latency counter reaches MULT_LAT.
  localparam int SCNT_W = $clog2(FRAME_LEN_MAX + 1);
  localparam int LCNT_W = $clog2(MULT_LAT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

endpackage

// File: rtl/matrix_ctrl_result_hold.sv
// matrix_ctrl_result_hold
// Capture register bank for the four accumulator words plus the result
// valid/ready hold. The captured words stay put until the next capture,
// including after the result has been accepted.
// Optional feature: MATRIX_CTRL_SYMCHK_EN adds sym_err_o, loaded at each
// capture with (a12 != a21).
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   capture_i           load a*_i into m*_o and raise m_valid_o
//   a11_i..a22_i        datapath accumulator words
//   m_ready_i           downstream accept
//   m_valid_o           result valid, held until accepted
//   m11_o..m22_o        captured matrix
//   sym_err_o           (optional) symmetry mismatch flag
module matrix_ctrl_result_hold
  import matrix_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             capture_i,
  input  logic [ACC_W-1:0] a11_i,
  input  logic [ACC_W-1:0] a12_i,
  input  logic [ACC_W-1:0] a21_i,
  input  logic [ACC_W-1:0] a22_i,
  input  logic             m_ready_i,
  output logic             m_valid_o,
  output logic [ACC_W-1:0] m11_o,
  output logic [ACC_W-1:0] m12_o,
  output logic [ACC_W-1:0] m21_o,
  output logic [ACC_W-1:0] m22_o
`ifdef MATRIX_CTRL_SYMCHK_EN
  ,
  output logic             sym_err_o
`endif
);

  logic [ACC_W-1:0] m11_q, m11_d;
  logic [ACC_W-1:0] m12_q, m12_d;
  logic [ACC_W-1:0] m21_q, m21_d;
  logic [ACC_W-1:0] m22_q, m22_d;
  logic             valid_q, valid_d;

  always_comb begin
    m11_d   = m11_q;
    m12_d   = m12_q;
    m21_d   = m21_q;
    m22_d   = m22_q;
    valid_d = valid_q;
    if (capture_i) begin
      m11_d   = a11_i;
      m12_d   = a12_i;
      m21_d   = a21_i;
      m22_d   = a22_i;
      valid_d = 1'b1;
    end else if (valid_q && m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      m11_q   <= '0;
      m12_q   <= '0;
      m21_q   <= '0;
      m22_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      m11_q   <= m11_d;
      m12_q   <= m12_d;
      m21_q   <= m21_d;
      m22_q   <= m22_d;
      valid_q <= valid_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m11_o     = m11_q;
  assign m12_o     = m12_q;
  assign m21_o     = m21_q;
  assign m22_o     = m22_q;

`ifdef MATRIX_CTRL_SYMCHK_EN
  logic sym_q, sym_d;

  always_comb begin
    sym_d = sym_q;
    if (capture_i) begin
      sym_d = (a12_i != a21_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sym_q <= 1'b0;
    end else begin
      sym_q <= sym_d;
    end
  end

  assign sym_err_o = sym_q;
`endif

endmodule

// File: rtl/matrix_mult_ctrl.sv
// matrix_mult_ctrl
// Frame sequencer for the 2x2 channel-product datapath: clears the
// accumulators, feeds FRAME_LEN sample pairs with a gated multiply enable,
// waits out the datapath latency, then presents the captured matrix.
// Optional feature: define MATRIX_CTRL_SYMCHK_EN to add O_sym_err
// (set at capture when I_a12 != I_a21).
// Parameters: FRAME_LEN (2..255) sample pairs per frame,
//             MULT_LAT  (1..7) datapath latency in cycles.
// Ports:
//   I_sys_clk, I_sys_rstn          clock, synchronous active-low reset
//   I_start                        frame request (only seen in IDLE)
//   I_s_valid/O_s_ready            sample stream handshake
//   I_s_cha, I_s_chb               channel samples
//   O_mult_ena, O_channela/b       registered enable and samples to datapath
//   O_acc_clr_n                    one-cycle active-low accumulator clear
//   I_a11..I_a22                   datapath accumulator words
//   O_m_valid/I_m_ready            result handshake
//   O_m11..O_m22                   captured matrix
//   O_busy                         high outside IDLE
//
// state | meaning
// IDLE  | waiting for I_start
// CLEAR | one-cycle accumulator clear, sample counter zeroed
// FEED  | accepting sample pairs until FRAME_LEN handshakes
// DRAIN | MULT_LAT+1 cycles for the last product to land; capture on last
// OUT   | result held valid until I_m_ready
module matrix_mult_ctrl
  import matrix_ctrl_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int MULT_LAT  = 1
) (
  input  logic              I_sys_clk,
  input  logic              I_sys_rstn,
  input  logic              I_start,
  input  logic              I_s_valid,
  output logic              O_s_ready,
  input  logic [DATA_W-1:0] I_s_cha,
  input  logic [DATA_W-1:0] I_s_chb,
  output logic              O_mult_ena,
  output logic [DATA_W-1:0] O_channela,
  output logic [DATA_W-1:0] O_channelb,
  output logic              O_acc_clr_n,
  input  logic [ACC_W-1:0]  I_a11,
  input  logic [ACC_W-1:0]  I_a12,
  input  logic [ACC_W-1:0]  I_a21,
  input  logic [ACC_W-1:0]  I_a22,
  output logic              O_m_valid,
  input  logic              I_m_ready,
  output logic [ACC_W-1:0]  O_m11,
  output logic [ACC_W-1:0]  O_m12,
  output logic [ACC_W-1:0]  O_m21,
  output logic [ACC_W-1:0]  O_m22,
  output logic              O_busy
`ifdef MATRIX_CTRL_SYMCHK_EN
  ,
  output logic              O_sym_err
`endif
);

  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(FRAME_LEN - 1);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(MULT_LAT);

  state_e              state_q, state_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic                s_ready_q, s_ready_d;
  logic                mult_ena_q, mult_ena_d;
  logic [DATA_W-1:0]   cha_q, cha_d;
  logic [DATA_W-1:0]   chb_q, chb_d;
  logic                acc_clr_n_q, acc_clr_n_d;
  logic                capture;
  logic                hs;

  // s_ready_q is only ever high in FEED, so it doubles as the FEED qualifier.
  assign hs = s_ready_q & I_s_valid;

  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    lcnt_d     = lcnt_q;
    mult_ena_d = 1'b0;
    cha_d      = cha_q;
    chb_d      = chb_q;
    capture    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (I_start) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        scnt_d  = '0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (hs) begin
          cha_d      = I_s_cha;
          chb_d      = I_s_chb;
          mult_ena_d = 1'b1;
          scnt_d     = scnt_q + SCNT_W'(1);
          if (scnt_q == SCNT_LAST) begin
            lcnt_d  = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (lcnt_q == LCNT_LAST) begin
          capture = 1'b1;
          state_d = ST_OUT;
        end else begin
          lcnt_d = lcnt_q + LCNT_W'(1);
        end
      end
      ST_OUT: begin
        if (I_m_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered from the next state so both flags line up with the state.
    s_ready_d   = (state_d == ST_FEED);
    acc_clr_n_d = (state_d != ST_CLEAR);
  end

  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rstn) begin
      state_q     <= ST_IDLE;
      scnt_q      <= '0;
      lcnt_q      <= '0;
      s_ready_q   <= 1'b0;
      mult_ena_q  <= 1'b0;
      cha_q       <= '0;
      chb_q       <= '0;
      acc_clr_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      lcnt_q      <= lcnt_d;
      s_ready_q   <= s_ready_d;
      mult_ena_q  <= mult_ena_d;
      cha_q       <= cha_d;
      chb_q       <= chb_d;
      acc_clr_n_q <= acc_clr_n_d;
    end
  end

  assign O_s_ready   = s_ready_q;
  assign O_mult_ena  = mult_ena_q;
  assign O_channela  = cha_q;
  assign O_channelb  = chb_q;
  assign O_acc_clr_n = acc_clr_n_q;
  assign O_busy      = (state_q != ST_IDLE);

  matrix_ctrl_result_hold u_hold (
    .clk_i     (I_sys_clk),
    .rst_ni    (I_sys_rstn),
    .capture_i (capture),
    .a11_i     (I_a11),
    .a12_i     (I_a12),
    .a21_i     (I_a21),
    .a22_i     (I_a22),
    .m_ready_i (I_m_ready),
    .m_valid_o (O_m_valid),
    .m11_o     (O_m11),
    .m12_o     (O_m12),
    .m21_o     (O_m21),
    .m22_o     (O_m22)
`ifdef MATRIX_CTRL_SYMCHK_EN
    ,
    .sym_err_o (O_sym_err)
`endif
  );

endmodule

// File: tb/tb_matrix_mult_ctrl.sv
`timescale 1ns/1ps
module tb_matrix_mult_ctrl;

  localparam int LAT = 1;
  localparam int FL0 = 4;
  localparam int FL1 = 2;

  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_FEED  = 2;
  localparam int P_DRAIN = 3;
  localparam int P_OUT   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [7:0]  cha, chb;
  logic [1:0]  start, s_valid, m_ready;
  logic [1:0]  o_ready, o_ena, o_clrn, o_valid, o_busy;
  logic [1:0][7:0]  o_cha, o_chb;
  logic [1:0][15:0] o_m11, o_m12, o_m21, o_m22;
  logic [1:0][15:0] acc11 = '0, acc12 = '0, acc21 = '0, acc22 = '0;
  logic [1:0][15:0] ia21;
  logic [1:0]  fsym = '0;
`ifdef MATRIX_CTRL_SYMCHK_EN
  logic [1:0]  o_sym;
  logic [1:0]  e_sym;
`endif

  int vectors = 0;
  int miscompares = 0;
  int pcyc = 0;

  // Model state (written only by the compare process)
  int ph [2];
  int nhs [2];
  int dwait [2];
  int s11 [2], s12 [2], s22 [2];
  int ena_cnt [2];
  logic [1:0]       e_ena;
  logic [1:0][7:0]  e_cha, e_chb;
  logic [1:0][15:0] e_m11, e_m12, e_m21, e_m22;
  logic             mdl_ok = 1'b0;
  logic             hsm;

  matrix_mult_ctrl #(.FRAME_LEN(FL0), .MULT_LAT(LAT)) u_dut0 (
    .I_sys_clk(clk), .I_sys_rstn(rstn), .I_start(start[0]),
    .I_s_valid(s_valid[0]), .O_s_ready(o_ready[0]),
    .I_s_cha(cha), .I_s_chb(chb),
    .O_mult_ena(o_ena[0]), .O_channela(o_cha[0]), .O_channelb(o_chb[0]),
    .O_acc_clr_n(o_clrn[0]),
    .I_a11(acc11[0]), .I_a12(acc12[0]), .I_a21(ia21[0]), .I_a22(acc22[0]),
    .O_m_valid(o_valid[0]), .I_m_ready(m_ready[0]),
    .O_m11(o_m11[0]), .O_m12(o_m12[0]), .O_m21(o_m21[0]), .O_m22(o_m22[0]),
    .O_busy(o_busy[0])
`ifdef MATRIX_CTRL_SYMCHK_EN
    , .O_sym_err(o_sym[0])
`endif
  );

  matrix_mult_ctrl #(.FRAME_LEN(FL1), .MULT_LAT(LAT)) u_dut1 (
    .I_sys_clk(clk), .I_sys_rstn(rstn), .I_start(start[1]),
    .I_s_valid(s_valid[1]), .O_s_ready(o_ready[1]),
    .I_s_cha(cha), .I_s_chb(chb),
    .O_mult_ena(o_ena[1]), .O_channela(o_cha[1]), .O_channelb(o_chb[1]),
    .O_acc_clr_n(o_clrn[1]),
    .I_a11(acc11[1]), .I_a12(acc12[1]), .I_a21(ia21[1]), .I_a22(acc22[1]),
    .O_m_valid(o_valid[1]), .I_m_ready(m_ready[1]),
    .O_m11(o_m11[1]), .O_m12(o_m12[1]), .O_m21(o_m21[1]), .O_m22(o_m22[1]),
    .O_busy(o_busy[1])
`ifdef MATRIX_CTRL_SYMCHK_EN
    , .O_sym_err(o_sym[1])
`endif
  );

  // Behavioural datapath: one-cycle MAC, not reset by rstn (only by clear).
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!o_clrn[g]) begin
        acc11[g] <= '0; acc12[g] <= '0; acc21[g] <= '0; acc22[g] <= '0;
      end else if (o_ena[g]) begin
        acc11[g] <= acc11[g] + ({8'd0, o_cha[g]} * {8'd0, o_cha[g]});
        acc12[g] <= acc12[g] + ({8'd0, o_cha[g]} * {8'd0, o_chb[g]});
        acc21[g] <= acc21[g] + ({8'd0, o_chb[g]} * {8'd0, o_cha[g]});
        acc22[g] <= acc22[g] + ({8'd0, o_chb[g]} * {8'd0, o_chb[g]});
      end
    end
  end
  assign ia21[0] = fsym[0] ? acc12[0] + 16'd1 : acc21[0];
  assign ia21[1] = fsym[1] ? acc12[1] + 16'd1 : acc21[1];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d at %0t: got %0d expected %0d", nm, d, $time, act, exp);
    end
  endtask

  // Compare current cycle against the model, then advance the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mdl_ok) begin
        chk("s_ready",   d, 32'(o_ready[d]), 32'(ph[d] == P_FEED));
        chk("busy",      d, 32'(o_busy[d]),  32'(ph[d] != P_IDLE));
        chk("acc_clr_n", d, 32'(o_clrn[d]),  32'(ph[d] != P_CLEAR));
        chk("m_valid",   d, 32'(o_valid[d]), 32'(ph[d] == P_OUT));
        chk("mult_ena",  d, 32'(o_ena[d]),   32'(e_ena[d]));
        chk("channela",  d, 32'(o_cha[d]),   32'(e_cha[d]));
        chk("channelb",  d, 32'(o_chb[d]),   32'(e_chb[d]));
        chk("m11",       d, 32'(o_m11[d]),   32'(e_m11[d]));
        chk("m12",       d, 32'(o_m12[d]),   32'(e_m12[d]));
        chk("m21",       d, 32'(o_m21[d]),   32'(e_m21[d]));
        chk("m22",       d, 32'(o_m22[d]),   32'(e_m22[d]));
`ifdef MATRIX_CTRL_SYMCHK_EN
        chk("sym_err",   d, 32'(o_sym[d]),   32'(e_sym[d]));
`endif
        if (o_ena[d] === 1'b1) ena_cnt[d]++;
      end
      if (!rstn) begin
        ph[d] = P_IDLE; nhs[d] = 0; dwait[d] = 0;
        e_ena[d] = 1'b0; e_cha[d] = '0; e_chb[d] = '0;
        e_m11[d] = '0; e_m12[d] = '0; e_m21[d] = '0; e_m22[d] = '0;
`ifdef MATRIX_CTRL_SYMCHK_EN
        e_sym[d] = 1'b0;
`endif
      end else begin
        hsm = (ph[d] == P_FEED) && s_valid[d];
        e_ena[d] = hsm;
        if (hsm) begin
          e_cha[d] = cha; e_chb[d] = chb;
          s11[d] += int'(cha) * int'(cha);
          s12[d] += int'(cha) * int'(chb);
          s22[d] += int'(chb) * int'(chb);
          nhs[d]++;
        end
        case (ph[d])
          P_IDLE:  if (start[d]) begin
                     ph[d] = P_CLEAR; nhs[d] = 0; s11[d] = 0; s12[d] = 0; s22[d] = 0;
                   end
          P_CLEAR: ph[d] = P_FEED;
          P_FEED:  if (hsm && nhs[d] == ((d == 0) ? FL0 : FL1)) begin
                     ph[d] = P_DRAIN; dwait[d] = LAT;
                   end
          P_DRAIN: if (dwait[d] == 0) begin
                     ph[d] = P_OUT;
                     e_m11[d] = 16'(s11[d]);
                     e_m12[d] = 16'(s12[d]);
                     e_m21[d] = 16'(s12[d] + (fsym[d] ? 1 : 0));
                     e_m22[d] = 16'(s22[d]);
`ifdef MATRIX_CTRL_SYMCHK_EN
                     e_sym[d] = fsym[d];
`endif
                   end else begin
                     dwait[d]--;
                   end
          P_OUT:   if (m_ready[d]) ph[d] = P_IDLE;
          default: ph[d] = P_IDLE;
        endcase
      end
    end
    if (!rstn) mdl_ok = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    pcyc++;
  endtask

  task automatic feed_one(input int d, input logic [7:0] a, input logic [7:0] b);
    int w;
    w = 0;
    cha = a; chb = b; s_valid[d] = 1'b1;
    while (!o_ready[d] && w < 20) begin step(); w++; end
    chk("hs_wait", d, 32'(w < 20), 32'd1);
    step();
    s_valid[d] = 1'b0;
  endtask

  // Runs one frame; lat = cycles from the I_start cycle to first O_m_valid.
  task automatic run_frame(input int d, input int n, input logic [7:0] av [4],
                           input logic [7:0] bv [4], input int stall, input int hold,
                           output int lat);
    int p0, w;
    m_ready[d] = (hold == 0);
    p0 = pcyc;
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (stall) step();
      feed_one(d, av[i], bv[i]);
    end
    w = 0;
    while (!o_valid[d] && w < 40) begin step(); w++; end
    chk("valid_wait", d, 32'(w < 40), 32'd1);
    lat = pcyc - p0;
    for (int j = 0; j < hold; j++) begin
      start[d] = (j == 1);
      step();
    end
    start[d] = 1'b0;
    m_ready[d] = 1'b1;
    step();
    m_ready[d] = 1'b0;
    chk("idle_after_accept", d, 32'(o_busy[d]), 32'd0);
  endtask

  logic [7:0] va [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
  logic [7:0] vb [4] = '{8'd4, 8'd3, 8'd2, 8'd1};
  logic [7:0] v2 [4] = '{8'd2, 8'd2, 8'd2, 8'd2};
  logic [7:0] vf [4] = '{8'd255, 8'd255, 8'd0, 8'd0};

  initial begin
    int lat, c0;
    rstn = 1'b0; start = '0; s_valid = '0; m_ready = '0; cha = '0; chb = '0;
    repeat (3) step();
    rstn = 1'b1;
    chk("rst_busy",    0, 32'(o_busy[0]),  32'd0);
    chk("rst_ready",   0, 32'(o_ready[0]), 32'd0);
    chk("rst_clr_n",   0, 32'(o_clrn[0]),  32'd1);
    chk("rst_m_valid", 0, 32'(o_valid[0]), 32'd0);
    step();

    // Basic frame
    c0 = ena_cnt[0];
    run_frame(0, 4, va, vb, 0, 0, lat);
    chk("basic_latency", 0, 32'(lat), 32'd8);
    chk("basic_ena_pulses", 0, 32'(ena_cnt[0] - c0), 32'd4);
    chk("basic_m11", 0, 32'(o_m11[0]), 32'd30);
    chk("basic_m12", 0, 32'(o_m12[0]), 32'd20);
    chk("basic_m21", 0, 32'(o_m21[0]), 32'd20);
    chk("basic_m22", 0, 32'(o_m22[0]), 32'd30);
    chk("model_m11", 0, 32'(e_m11[0]), 32'd30);
    chk("model_m12", 0, 32'(e_m12[0]), 32'd20);
    step();

    // Input stalls
    c0 = ena_cnt[0];
    run_frame(0, 4, va, vb, 3, 0, lat);
    chk("stall_ena_pulses", 0, 32'(ena_cnt[0] - c0), 32'd4);
    chk("stall_m11", 0, 32'(o_m11[0]), 32'd30);
    chk("stall_m21", 0, 32'(o_m21[0]), 32'd20);
    step();

    // Output backpressure with an ignored start in the hold window
    run_frame(0, 4, vb, va, 0, 5, lat);
    chk("bp_m22", 0, 32'(o_m22[0]), 32'd30);
    repeat (3) step();
    chk("bp_still_idle", 0, 32'(o_busy[0]), 32'd0);

    // Reset mid-frame after the 2nd sample
    start[0] = 1'b1; step(); start[0] = 1'b0;
    feed_one(0, 8'd9, 8'd7);
    feed_one(0, 8'd5, 8'd6);
    rstn = 1'b0; step(); rstn = 1'b1;
    chk("mid_rst_busy",  0, 32'(o_busy[0]),  32'd0);
    chk("mid_rst_ready", 0, 32'(o_ready[0]), 32'd0);
    chk("mid_rst_cha",   0, 32'(o_cha[0]),   32'd0);
    chk("mid_rst_m11",   0, 32'(o_m11[0]),   32'd0);
    chk("mid_rst_valid", 0, 32'(o_valid[0]), 32'd0);
    step();
    run_frame(0, 4, v2, v2, 0, 0, lat);
    chk("residue_m11", 0, 32'(o_m11[0]), 32'd16);
    chk("residue_m12", 0, 32'(o_m12[0]), 32'd16);
    chk("residue_m21", 0, 32'(o_m21[0]), 32'd16);
    chk("residue_m22", 0, 32'(o_m22[0]), 32'd16);
    step();

    // Accumulator wrap on the FRAME_LEN=2 instance
    run_frame(1, 2, vf, vf, 0, 0, lat);
    chk("wrap_m11", 1, 32'(o_m11[1]), 32'd64514);
    chk("wrap_m12", 1, 32'(o_m12[1]), 32'd64514);
    chk("model_wrap_m22", 1, 32'(e_m22[1]), 32'd64514);
    step();

`ifdef MATRIX_CTRL_SYMCHK_EN
    fsym[0] = 1'b1;
    run_frame(0, 4, va, vb, 0, 0, lat);
    chk("sym_err_set", 0, 32'(o_sym[0]), 32'd1);
    chk("sym_m21",     0, 32'(o_m21[0]), 32'd21);
    fsym[0] = 1'b0;
    step();
    run_frame(0, 4, va, vb, 0, 0, lat);
    chk("sym_err_clr", 0, 32'(o_sym[0]), 32'd0);
    step();
`endif

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
